layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of priority layers (2..8).
REQ-002 SHALL have parameter CBITS, default 2, bits per colour channel (1..4).
REQ-003 SHALL have parameter PIPE, default 1, extra output delay stages (0..4).
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port x, y  input  10 each  current beam coordinates.
REQ-007 SHALL have ports blank, hsync_in, vsync_in  input  1 each  beam timing from the VGA beam generator.
REQ-008 SHALL have port frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-009 SHALL have port layer_hit  input  NUM_LAYERS  per-layer pixel coverage; bit 0 is highest priority.
REQ-010 SHALL have port layer_en  input  NUM_LAYERS  per-layer enable.
REQ-011 SHALL have port layer_color  input  NUM_LAYERS*3*CBITS  colour {R,G,B} per layer; layer i occupies slice i.
REQ-012 SHALL have port bg_mode  input  2  background: 0 black, 1 checker, 2 solid, 3 black.
REQ-013 SHALL have port bg_color  input  3*CBITS  solid background colour.
REQ-014 SHALL have port fade_start  input  1  request to toggle the fade direction.
REQ-015 SHALL have port rgb_out  output  3*CBITS  registered {R,G,B}.
REQ-016 SHALL have ports hsync_out, vsync_out  output  1 each  syncs aligned with rgb_out.
REQ-017 SHALL have port overlap_mask  output  NUM_LAYERS  per-layer occlusion flags for the previous frame.
REQ-018 SHALL have port fade_busy  output  1  high while fade state is FADE_OUT or FADE_IN.

Function
REQ-019 Pixel selection SHALL be: blank -> 0; else the lowest-index layer with hit&en -> its colour; else background.
REQ-020 Checker background SHALL set channel MSB to x[5]^y[5] (R), x[4]^y[4] (G), x[3]^y[3] (B), with all other bits 0.
REQ-021 The selected colour SHALL be right-shifted per channel by fade level L (0..CBITS), zero-filled; L=CBITS yields black.
REQ-022 Latency from x/y/hit/colour/blank/sync inputs to rgb_out/hsync_out/vsync_out SHALL be exactly PIPE+1 cycles, identical for all three.
REQ-023 Layer i SHALL accumulate an overlap flag when, on a non-blank cycle, it has hit&en and any layer j<i also has hit&en.
REQ-024 On frame_start, overlap_mask SHALL load the accumulated flags ORed with the current cycle's flags, and the accumulator SHALL clear.
REQ-025 Between frame_start pulses overlap_mask SHALL hold its value.
REQ-026 The fade FSM SHALL have states IDLE(L=0), FADE_OUT, DARK(L=CBITS) and FADE_IN.
REQ-027 fade_start in IDLE SHALL go to FADE_OUT; fade_start in DARK SHALL go to FADE_IN; fade_start in FADE_OUT or FADE_IN SHALL be ignored.
REQ-028 In FADE_OUT, each frame_start SHALL increment L; the FSM SHALL enter DARK on the same edge that L reaches CBITS.
REQ-029 In FADE_IN, each frame_start SHALL decrement L; the FSM SHALL enter IDLE on the same edge that L reaches 0.
REQ-030 When fade_start and frame_start coincide in IDLE, the state SHALL change to FADE_OUT with L unchanged; stepping SHALL begin at the next frame_start.
REQ-031 L SHALL apply to the pixel at pipeline entry; a change of L SHALL not affect pixels already in the pipeline.

Reset
REQ-032 On rst: rgb_out=0, hsync_out=vsync_out=0, overlap_mask=0, accumulator=0, FSM=IDLE, L=0, fade_busy=0, and all pipeline stages=0.
REQ-033 rst asserted mid-fade SHALL return the FSM to IDLE with L=0 on the next edge.
REQ-034 rst asserted mid-frame SHALL discard the partial overlap accumulation.

Structure
REQ-035 A shared package compositor_pkg SHALL hold the fade state enum and the BG_BLACK/BG_CHECKER/BG_SOLID constants.
REQ-036 A sub-module comp_delay (parametrised width and depth shift register) SHALL implement the PIPE stages for colour and syncs.

Verification
REQ-037 Bench: layers 0 and 2 hit&en, layer 0 colour 6'b110000 -> rgb_out=6'b110000 exactly PIPE+1 cycles later, with syncs aligned.
REQ-038 Bench: no hits, bg_mode=1, x=32, y=0 -> rgb_out=6'b100000; blank=1 -> 0.
REQ-039 Bench: layer 1 overlaps layer 0 for one pixel in frame N -> overlap_mask=4'b0010 after frame_start; a clean frame N+1 -> 4'b0000.
REQ-040 Bench: fade_start in IDLE with CBITS=2 -> L=1 and L=2 (DARK) at the next two frame_starts with fade_busy=1 throughout; white then becomes 0.
REQ-041 Bench: fade_start during FADE_OUT -> ignored; fade_start in DARK -> returns to IDLE after 2 frames.
REQ-042 Bench: rst mid-FADE_IN and mid-frame -> all outputs 0 and FSM IDLE on the next cycle.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor: fade FSM states,
// background mode encodings and the fade-level width.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    DARK     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam logic [1:0] BG_BLACK   = 2'd0;
  localparam logic [1:0] BG_CHECKER = 2'd1;
  localparam logic [1:0] BG_SOLID   = 2'd2;

  // Wide enough for fade levels 0..4 (largest supported CBITS).
  localparam int LVL_W = 3;

endpackage

// File: rtl/comp_delay.sv
// Parametrised shift-register delay line, cleared by synchronous reset.
// STAGES = 0 degenerates to a straight wire.
module comp_delay #(
  parameter int DATA_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = clk ^ rst;
      assign q = d;
    end else begin : g_shift
      logic [DATA_W-1:0] stage_q [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/layer_compositor.sv
// Priority layer compositor: picks the top visible layer or background, applies
// a frame-stepped fade, and reports per-frame layer occlusion.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int CBITS      = 2,
  parameter int PIPE       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [9:0]                      x,
  input  logic [9:0]                      y,
  input  logic                            blank,
  input  logic                            hsync_in,
  input  logic                            vsync_in,
  input  logic                            frame_start,
  input  logic [NUM_LAYERS-1:0]           layer_hit,
  input  logic [NUM_LAYERS-1:0]           layer_en,
  input  logic [NUM_LAYERS*3*CBITS-1:0]   layer_color,
  input  logic [1:0]                      bg_mode,
  input  logic [3*CBITS-1:0]              bg_color,
  input  logic                            fade_start,
  output logic [3*CBITS-1:0]              rgb_out,
  output logic                            hsync_out,
  output logic                            vsync_out,
  output logic [NUM_LAYERS-1:0]           overlap_mask,
  output logic                            fade_busy
);

  localparam int CW = 3 * CBITS;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(CBITS);

  // Per-channel zero-filled right shift; a level of CBITS gives black.
  function automatic logic [CW-1:0] fade_pix(input logic [CW-1:0] pix,
                                             input logic [LVL_W-1:0] lvl);
    logic [CBITS-1:0] r, g, b;
    {r, g, b} = pix;
    return {r >> lvl, g >> lvl, b >> lvl};
  endfunction

  logic [NUM_LAYERS-1:0] hit_en;
  logic [NUM_LAYERS-1:0] flags_now;
  logic [NUM_LAYERS-1:0] overlap_acc;
  logic [CW-1:0]         bg_pix;
  logic [CW-1:0]         sel_pix;
  logic [CW-1:0]         rgb_p0;
  logic                  hsync_p0;
  logic                  vsync_p0;
  logic [CW+1:0]         dly_q;
  fade_state_t           state, state_nxt;
  logic [LVL_W-1:0]      level, level_nxt;
  logic                  unused_xy;

  assign hit_en    = layer_hit & layer_en;
  assign unused_xy = ^{x[9:6], x[2:0], y[9:6], y[2:0]};

  always_comb begin
    bg_pix = '0;
    case (bg_mode)
      BG_CHECKER: begin
        bg_pix[3*CBITS-1] = x[5] ^ y[5];
        bg_pix[2*CBITS-1] = x[4] ^ y[4];
        bg_pix[CBITS-1]   = x[3] ^ y[3];
      end
      BG_SOLID: bg_pix = bg_color;
      default:  bg_pix = '0;
    endcase
  end

  // Scan from the lowest priority upward so the lowest-index hit wins.
  always_comb begin
    sel_pix = bg_pix;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit_en[i]) sel_pix = layer_color[i*CW +: CW];
    end
    if (blank) sel_pix = '0;
  end

  always_comb begin
    logic seen;
    flags_now = '0;
    seen      = hit_en[0];
    for (int i = 1; i < NUM_LAYERS; i++) begin
      flags_now[i] = ~blank & hit_en[i] & seen;
      seen         = seen | hit_en[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overlap_acc  <= '0;
      overlap_mask <= '0;
    end else if (frame_start) begin
      overlap_acc  <= '0;
      overlap_mask <= overlap_acc | flags_now;
    end else begin
      overlap_acc  <= overlap_acc | flags_now;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    unique case (state)
      IDLE:     if (fade_start) state_nxt = FADE_OUT;
      FADE_OUT: if (frame_start) begin
        level_nxt = level + LVL_W'(1);
        if (level_nxt == LVL_MAX) state_nxt = DARK;
      end
      DARK:     if (fade_start) state_nxt = FADE_IN;
      FADE_IN:  if (frame_start) begin
        level_nxt = level - LVL_W'(1);
        if (level_nxt == '0) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  assign fade_busy = (state == FADE_OUT) || (state == FADE_IN);

  // Stage p0: selection and fade land in the entry register together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p0   <= '0;
      hsync_p0 <= 1'b0;
      vsync_p0 <= 1'b0;
    end else begin
      rgb_p0   <= fade_pix(sel_pix, level);
      hsync_p0 <= hsync_in;
      vsync_p0 <= vsync_in;
    end
  end

  // Stages p1..pPIPE: colour and syncs share one delay line to stay aligned.
  comp_delay #(
    .DATA_W (CW + 2),
    .STAGES (PIPE)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .d   ({rgb_p0, hsync_p0, vsync_p0}),
    .q   (dly_q)
  );

  assign {rgb_out, hsync_out, vsync_out} = dly_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor at defaults (4 layers, 2-bit channels,
// PIPE=1, so outputs trail inputs by two clocks).
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        blank, hsync_in, vsync_in, frame_start, fade_start;
  logic [3:0]  layer_hit, layer_en;
  logic [23:0] layer_color;
  logic [1:0]  bg_mode;
  logic [5:0]  bg_color;
  logic [5:0]  rgb_out;
  logic        hsync_out, vsync_out, fade_busy;
  logic [3:0]  overlap_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_compositor #(.NUM_LAYERS(4), .CBITS(2), .PIPE(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .x            (x),
    .y            (y),
    .blank        (blank),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .frame_start  (frame_start),
    .layer_hit    (layer_hit),
    .layer_en     (layer_en),
    .layer_color  (layer_color),
    .bg_mode      (bg_mode),
    .bg_color     (bg_color),
    .fade_start   (fade_start),
    .rgb_out      (rgb_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .overlap_mask (overlap_mask),
    .fade_busy    (fade_busy)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic pulse_fade();
    fade_start = 1'b1;
    tick(1);
    fade_start = 1'b0;
  endtask

  initial begin
    // Busy inputs during reset must not leak through.
    rst = 1'b1; x = '0; y = '0; blank = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    frame_start = 1'b0; fade_start = 1'b0; layer_hit = 4'b1111; layer_en = 4'b1111;
    layer_color = {6'b111111, 6'b000011, 6'b001100, 6'b110000};
    bg_mode = 2'd0; bg_color = '0;
    tick(3);
    check("reset_rgb", rgb_out, 6'b0);
    check("reset_hsync", hsync_out, 1'b0);
    check("reset_vsync", vsync_out, 1'b0);
    check("reset_mask", overlap_mask, 4'b0);
    check("reset_busy", fade_busy, 1'b0);

    rst = 1'b0; layer_hit = 4'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    tick(3);
    check("idle_black", rgb_out, 6'b0);

    // Layers 0 and 2 hit: layer 0 wins, exactly two clocks later.
    layer_hit = 4'b0101; hsync_in = 1'b1;
    tick(1);
    check("latency_early_rgb", rgb_out, 6'b0);
    check("latency_early_hsync", hsync_out, 1'b0);
    tick(1);
    check("prio_rgb", rgb_out, 6'b110000);
    check("prio_hsync", hsync_out, 1'b1);
    check("prio_vsync", vsync_out, 1'b0);

    layer_en = 4'b1110; hsync_in = 1'b0; vsync_in = 1'b1;
    tick(2);
    check("prio_disabled_rgb", rgb_out, 6'b000011);
    check("prio_disabled_vsync", vsync_out, 1'b1);
    check("prio_disabled_hsync", hsync_out, 1'b0);

    // Backgrounds.
    layer_hit = 4'b0; vsync_in = 1'b0; bg_mode = 2'd1; x = 10'd32; y = 10'd0;
    tick(2);
    check("checker_32_0", rgb_out, 6'b100000);
    x = 10'd8; y = 10'd16;
    tick(2);
    check("checker_8_16", rgb_out, 6'b001010);
    blank = 1'b1; layer_hit = 4'b0011;
    tick(2);
    check("blank_black", rgb_out, 6'b0);
    blank = 1'b0; layer_hit = 4'b0; bg_mode = 2'd2; bg_color = 6'b011001;
    tick(2);
    check("solid_bg", rgb_out, 6'b011001);
    bg_mode = 2'd3;
    tick(2);
    check("mode3_black", rgb_out, 6'b0);
    bg_mode = 2'd0; layer_en = 4'b1111;

    // Overlap reporting; the earlier 0/2 overlap is still accumulated.
    pulse_frame();
    check("mask_prior", overlap_mask, 4'b0100);
    layer_hit = 4'b0011;
    tick(1);
    layer_hit = 4'b0;
    tick(3);
    check("mask_hold", overlap_mask, 4'b0100);
    pulse_frame();
    check("mask_frame_n", overlap_mask, 4'b0010);
    layer_hit = 4'b0100; tick(1);
    layer_hit = 4'b1000; tick(1);
    layer_hit = 4'b0;
    pulse_frame();
    check("mask_clean_frame", overlap_mask, 4'b0000);
    layer_hit = 4'b1001; frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0; layer_hit = 4'b0;
    check("mask_same_cycle", overlap_mask, 4'b1000);
    tick(2);
    pulse_frame();
    check("mask_acc_cleared", overlap_mask, 4'b0000);

    // Fade: white layer 0, coincident fade_start/frame_start in IDLE.
    layer_color[5:0] = 6'b111111; layer_en = 4'b0001; layer_hit = 4'b0001;
    tick(2);
    check("fade_l0_rgb", rgb_out, 6'b111111);
    check("fade_idle_busy", fade_busy, 1'b0);
    fade_start = 1'b1; frame_start = 1'b1;
    tick(1);
    fade_start = 1'b0; frame_start = 1'b0;
    check("coincide_busy", fade_busy, 1'b1);
    tick(2);
    check("coincide_no_step", rgb_out, 6'b111111);
    pulse_frame();
    check("l1_busy", fade_busy, 1'b1);
    check("l1_inflight_a", rgb_out, 6'b111111);
    tick(1);
    check("l1_inflight_b", rgb_out, 6'b111111);
    tick(1);
    check("l1_rgb", rgb_out, 6'b010101);
    pulse_fade();
    check("fadeout_ignore_busy", fade_busy, 1'b1);
    tick(2);
    check("fadeout_ignore_rgb", rgb_out, 6'b010101);
    pulse_frame();
    check("dark_busy", fade_busy, 1'b0);
    tick(2);
    check("dark_rgb", rgb_out, 6'b0);
    pulse_frame();
    tick(2);
    check("dark_holds", rgb_out, 6'b0);
    check("dark_holds_busy", fade_busy, 1'b0);
    pulse_fade();
    check("fadein_busy", fade_busy, 1'b1);
    tick(2);
    check("fadein_wait_rgb", rgb_out, 6'b0);
    pulse_frame();
    tick(2);
    check("fadein_l1_rgb", rgb_out, 6'b010101);
    check("fadein_l1_busy", fade_busy, 1'b1);
    pulse_frame();
    check("fadein_idle_busy", fade_busy, 1'b0);
    tick(2);
    check("fadein_idle_rgb", rgb_out, 6'b111111);

    // Reset during FADE_IN with an overlap in progress.
    pulse_fade();
    pulse_frame();
    pulse_frame();
    pulse_fade();
    layer_en = 4'b0011; layer_hit = 4'b0011; hsync_in = 1'b1; vsync_in = 1'b1;
    tick(1);
    pulse_frame();
    check("prerst_mask", overlap_mask, 4'b0010);
    check("prerst_busy", fade_busy, 1'b1);
    tick(2);
    check("prerst_rgb", rgb_out, 6'b010101);
    check("prerst_hsync", hsync_out, 1'b1);
    rst = 1'b1;
    tick(1);
    check("rst_rgb", rgb_out, 6'b0);
    check("rst_hsync", hsync_out, 1'b0);
    check("rst_vsync", vsync_out, 1'b0);
    check("rst_mask", overlap_mask, 4'b0);
    check("rst_busy", fade_busy, 1'b0);
    rst = 1'b0; layer_hit = 4'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    tick(1);
    pulse_frame();
    check("rst_acc_discarded", overlap_mask, 4'b0000);
    layer_hit = 4'b0001;
    tick(2);
    check("rst_level_zero", rgb_out, 6'b111111);
    pulse_fade();
    check("rst_state_idle", fade_busy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
